// File: rtl/fir_out_pkg.sv
// Shared defaults and helpers for the FIR output decimator.
// Defining FIR_OUT_CONVERGENT_EN switches rounding to round-half-to-even.
package fir_out_pkg;

    localparam int IW_DEF    = 31;
    localparam int SHIFT_DEF = 11;
    localparam int OW_DEF    = 16;
    localparam int DW_DEF    = 8;

`ifdef FIR_OUT_CONVERGENT_EN
    localparam bit CONVERGENT = 1'b1;
`else
    localparam bit CONVERGENT = 1'b0;
`endif

    // odd is the LSB that survives the shift; it only matters for convergent rounding.
    function automatic logic [31:0] rnd_const(input int shift, input logic odd);
        logic [31:0] half;
        half = 32'd1 << (shift - 1);
        return CONVERGENT ? (half - 32'd1 + {31'd0, odd}) : half;
    endfunction

    function automatic int sat_max(input int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

    function automatic int sat_min(input int ow);
        return -(1 << (ow - 1));
    endfunction

endpackage

// File: rtl/fir_out_fifo2.sv
// Two-entry valid/ready FIFO; a push into a full FIFO is accepted only when
// the head is popped in the same cycle.
module fir_out_fifo2 #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_accept
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic         pop;

    always_comb begin
        pop      = (cnt_q != 2'd0) && i_ready;
        o_accept = i_push && ((cnt_q != 2'd2) || pop);
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        case ({pop, o_accept})
            2'b01: begin
                if (cnt_q == 2'd0) head_d = i_data;
                else               tail_d = i_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b10: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = i_data;
                end else begin
                    head_d = tail_q;
                    tail_d = i_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign o_valid = (cnt_q != 2'd0);
    assign o_full  = (cnt_q == 2'd2);
    assign o_data  = head_q;

endmodule

// File: rtl/fir_output_decimator.sv
// Decimate, round and saturate the FIR accumulator into a 2-entry output buffer.
// FIR_OUT_CONVERGENT_EN selects round-half-to-even; default is round-half-up.
module fir_output_decimator
    import fir_out_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int OW    = OW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic [IW-1:0] i_result,
    input  logic [DW-1:0] i_decim,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_sat,
    output logic          o_overflow,
    input  logic          i_clr_ovf
);

    localparam int RW = IW + 1 - SHIFT;
    localparam logic signed [RW-1:0] HI = RW'(sat_max(OW));
    localparam logic signed [RW-1:0] LO = RW'(sat_min(OW));

    logic                 ce_d_q, ce_d_d;
    logic                 load_q, load_d;
    logic [DW-1:0]        d_q, d_d, phase_q, phase_d;
    logic [1:0]           vld_pipe_q, vld_pipe_d;
    logic [IW-1:0]        a_q, a_d;
    logic signed [RW-1:0] b_q, b_d;
    logic                 sat_q, sat_d, ovf_q, ovf_d;
    logic                 keep, wrap, c_sat, accept, fifo_full;
    logic signed [IW:0]   sum;
    logic [OW-1:0]        c_data;

    always_comb begin
        ce_d_d  = i_ce;
        load_d  = 1'b0;
        d_d     = d_q;
        phase_d = phase_q;
        wrap    = (d_q <= DW'(1)) || (phase_q == d_q - DW'(1));
        keep    = ce_d_q && (phase_q == '0);
        // D is captured on the first clock out of reset and then only at period wraps.
        if (load_q) begin
            d_d = i_decim;
        end else if (ce_d_q) begin
            if (wrap) begin
                phase_d = '0;
                d_d     = i_decim;
            end else begin
                phase_d = phase_q + DW'(1);
            end
        end

        vld_pipe_d = {vld_pipe_q[0], keep};
        a_d        = keep ? i_result : a_q;
        sum        = $signed({a_q[IW-1], a_q}) + $signed((IW+1)'(rnd_const(SHIFT, a_q[SHIFT])));
        b_d        = vld_pipe_q[0] ? RW'(sum >>> SHIFT) : b_q;

        c_sat  = 1'b1;
        if (b_q > HI)      c_data = {1'b0, {(OW-1){1'b1}}};
        else if (b_q < LO) c_data = {1'b1, {(OW-1){1'b0}}};
        else begin
            c_data = b_q[OW-1:0];
            c_sat  = 1'b0;
        end

        sat_d = vld_pipe_q[1] && accept && c_sat;
        // A new drop wins over a same-cycle clear.
        if (vld_pipe_q[1] && !accept) ovf_d = 1'b1;
        else if (i_clr_ovf)           ovf_d = 1'b0;
        else                          ovf_d = ovf_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ce_d_q     <= 1'b0;
            load_q     <= 1'b1;
            d_q        <= '0;
            phase_q    <= '0;
            vld_pipe_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ce_d_q     <= ce_d_d;
            load_q     <= load_d;
            d_q        <= d_d;
            phase_q    <= phase_d;
            vld_pipe_q <= vld_pipe_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    fir_out_fifo2 #(.W(OW)) u_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_push   (vld_pipe_q[1]),
        .i_data   (c_data),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_full   (fifo_full),
        .o_accept (accept)
    );

    assign o_sat      = sat_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Self-checking bench for fir_output_decimator against a sample-level reference model.
module tb_fir_output_decimator;

    localparam int IW = 31, SHIFT = 11, OW = 16, DW = 8;
`ifdef FIR_OUT_CONVERGENT_EN
    localparam logic [15:0] TIE_EXP = 16'h0000;
`else
    localparam logic [15:0] TIE_EXP = 16'h0001;
`endif

    logic          i_clk = 1'b0, i_reset = 1'b0, i_ce = 1'b0, i_ready = 1'b1, i_clr_ovf = 1'b0;
    logic [IW-1:0] i_result = '0;
    logic [DW-1:0] i_decim = 8'd1;
    logic          o_valid, o_sat, o_overflow;
    logic [OW-1:0] o_data;

    int n_tests = 0, n_fail = 0;

    logic [15:0] mq[$];
    logic [15:0] got[$];
    logic        collect = 1'b0;
    logic        mce, a_v, b_v, a_s, b_s, m_ovf, m_sat, m_load;
    logic [15:0] a_d, b_d;
    int          m_since, m_per;

    logic [30:0] dvals [6] = '{31'h400, 31'hC00, 31'h7FFFFC00, 31'h3FFFFFFF, 31'h40000000, 31'h800};
    logic [15:0] ddat  [6] = '{TIE_EXP, 16'h0002, 16'h0000, 16'h7FFF, 16'h8000, 16'h0001};
    logic        dsat  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] dec_exp [8] = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd14, 16'd16, 16'd18, 16'd20};

    always #5 i_clk = ~i_clk;

    fir_output_decimator dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_result   (i_result),
        .i_decim    (i_decim),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_sat      (o_sat),
        .o_overflow (o_overflow),
        .i_clr_ovf  (i_clr_ovf)
    );

    // {sat, word}: exact rounding of value/2^SHIFT, then clamp to 16-bit signed.
    function automatic logic [16:0] ref_word(input logic [30:0] r);
        longint v, q, rem;
        v   = longint'($signed(r));
        q   = v >>> SHIFT;
        rem = v - q * 2048;
`ifdef FIR_OUT_CONVERGENT_EN
        if (rem > 1024 || (rem == 1024 && (q & 1) != 0)) q = q + 1;
`else
        if (rem >= 1024) q = q + 1;
`endif
        if (q > 32767)  return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    function automatic logic [30:0] rnd_sample();
        logic [31:0] r;
        r = $urandom;
        return r[31] ? {{10{r[20]}}, r[20:0]} : r[30:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_tests++;
        assert (got_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mce = 0; a_v = 0; b_v = 0; a_s = 0; b_s = 0; a_d = '0; b_d = '0;
        m_ovf = 0; m_sat = 0; m_load = 1; m_since = 0; m_per = 0;
    endtask

    // One clock edge of the reference: buffer, then pipeline, then sample selection.
    task automatic model_edge();
        logic ovf_new;
        logic [16:0] w;
        ovf_new = 0;
        m_sat   = 0;
        if (mq.size() > 0 && i_ready) void'(mq.pop_front());
        if (b_v) begin
            if (mq.size() < 2) begin
                mq.push_back(b_d);
                m_sat = b_s;
            end else ovf_new = 1;
        end
        m_ovf = ovf_new ? 1'b1 : (i_clr_ovf ? 1'b0 : m_ovf);
        b_v = a_v; b_d = a_d; b_s = a_s;
        a_v = 0;
        if (m_load) begin
            m_per  = int'(i_decim);
            m_load = 0;
        end else if (mce) begin
            if (m_since == 0) begin
                w = ref_word(i_result);
                a_v = 1; a_d = w[15:0]; a_s = w[16];
            end
            m_since++;
            if (m_since >= ((m_per < 2) ? 1 : m_per)) begin
                m_since = 0;
                m_per   = int'(i_decim);
            end
        end
        mce = i_ce;
    endtask

    task automatic check_outputs();
        chk("o_valid", o_valid, mq.size() > 0);
        if (mq.size() > 0) chk("o_data", o_data, mq[0]);
        chk("o_sat", o_sat, m_sat);
        chk("o_overflow", o_overflow, m_ovf);
        if (collect && o_valid === 1'b1 && i_ready) got.push_back(o_data);
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (!i_reset) model_edge();
        #1;
        check_outputs();
    endtask

    task automatic apply_reset(input logic [7:0] d);
        i_reset = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_sat", o_sat, 0);
        chk("rst_overflow", o_overflow, 0);
        tick();
        tick();
        i_decim = d;
        i_reset = 1'b0;
    endtask

    initial begin
        logic [30:0] r0, r1;
        logic [16:0] w;
        int lat, vcnt;

        #1;
        apply_reset(8'd1);

        // Directed rounding and saturation points, one sample each.
        for (int i = 0; i < 6; i++) begin
            i_ce = 1; tick();
            i_ce = 0; i_result = dvals[i]; tick();
            i_result = rnd_sample(); tick(); tick();
            chk("dir_valid", o_valid, 1);
            chk("dir_data", o_data, ddat[i]);
            chk("dir_sat", o_sat, dsat[i]);
            tick();
        end

        // Single strobe latency.
        i_ce = 1; tick(); lat = 1;
        i_ce = 0; i_result = rnd_sample();
        while (o_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        chk("latency", lat, 4);
        tick(); tick();

        // Continuous strobes, D=1, ready high: no bubbles.
        vcnt = 0;
        i_ce = 1;
        for (int k = 0; k < 40; k++) begin
            i_result = rnd_sample();
            tick();
            if (k >= 3 && o_valid === 1'b1) vcnt++;
        end
        chk("throughput", vcnt, 37);
        i_ce = 0;
        repeat (5) tick();

        // Decimation by 4 on a ramp, switching to 2 mid-period.
        apply_reset(8'd4);
        got.delete();
        collect = 1;
        for (int k = 0; k < 23; k++) begin
            i_ce = (k < 22);
            i_result = (k == 0) ? '0 : IW'((k - 1) * 2048);
            if (k == 10) i_decim = 8'd2;
            tick();
        end
        repeat (6) tick();
        collect = 0;
        chk("dec_count", got.size(), 8);
        for (int j = 0; j < 8; j++)
            if (j < got.size()) chk("dec_word", got[j], dec_exp[j]);

        // Back-pressure: two words held, the rest dropped and flagged.
        apply_reset(8'd1);
        i_ready = 0;
        r0 = '0; r1 = '0;
        for (int k = 0; k < 7; k++) begin
            i_ce = (k < 6);
            i_result = rnd_sample();
            if (k == 1) r0 = i_result;
            if (k == 2) r1 = i_result;
            tick();
        end
        tick(); tick();
        w = ref_word(r0);
        chk("bp_head0", o_data, w[15:0]);
        chk("bp_ovf", o_overflow, 1);
        i_ready = 1; tick();
        w = ref_word(r1);
        chk("bp_head1", o_data, w[15:0]);
        chk("bp_valid", o_valid, 1);
        tick();
        i_clr_ovf = 1; tick();
        i_clr_ovf = 0;
        chk("bp_clr", o_overflow, 0);
        i_ce = 1;
        repeat (20) begin i_result = rnd_sample(); tick(); end
        i_ce = 0;
        repeat (5) tick();
        chk("bp_no_loss", o_overflow, 0);

        // Reset with two words buffered and two in flight.
        i_ready = 0; i_ce = 1;
        repeat (5) begin i_result = rnd_sample(); tick(); end
        chk("pre_rst_valid", o_valid, 1);
        i_ce = 0;
        apply_reset(8'd1);
        i_ready = 1;
        tick();
        chk("post_rst_idle", o_valid, 0);
        i_ce = 1; tick(); lat = 1;
        i_ce = 0; i_result = rnd_sample();
        while (o_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        chk("latency_after_reset", lat, 4);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
